// File: rtl/conv_encoder_if.sv
// Handshake bundle between a bit source/codeword sink and conv_encoder.
// The slave side is the encoder; master is whoever feeds bits and drains codewords.
interface conv_encoder_if #(
   parameter int CODE_NUM = 2
);
   logic                i_start;
   logic                i_bit;
   logic                i_valid;
   logic                o_ready;
   logic [CODE_NUM-1:0] o_code;
   logic                o_valid;
   logic                i_ready;
   logic                o_last;
   logic                o_busy;

   modport master (
      output i_start, i_bit, i_valid, i_ready,
      input  o_ready, o_code, o_valid, o_last, o_busy
   );

   modport slave (
      input  i_start, i_bit, i_valid, i_ready,
      output o_ready, o_code, o_valid, o_last, o_busy
   );
endinterface

// File: rtl/conv_encoder.sv
// Rate-1/CODE_NUM feed-forward convolutional encoder with zero-tail termination.
// One registered codeword per input bit, then CONSTR_LEN-1 tail codewords per frame.
module conv_encoder #(
   parameter int                             CONSTR_LEN = 3,
   parameter int                             CODE_NUM   = 2,
   parameter logic [CODE_NUM*CONSTR_LEN-1:0] GEN_POLY   = {3'b101, 3'b111},
   parameter int                             FRAME_LEN  = 8
) (
   input logic           clk,
   input logic           rst,
   conv_encoder_if.slave bus
);
   localparam int BW = $clog2(FRAME_LEN + 1);
   localparam int TW = $clog2(CONSTR_LEN);

   typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

   state_t                state_q, state_d;
   logic [CONSTR_LEN-2:0] sreg_q, sreg_d;
   logic [BW-1:0]         bcnt_q, bcnt_d;
   logic [TW-1:0]         tcnt_q, tcnt_d;
   logic [CODE_NUM-1:0]   code_q, code_d;
   logic                  valid_q, last_q;
   logic                  slot_free, ready, accept, step, last_step;
   logic [CONSTR_LEN-1:0] window;

   always_comb begin
      slot_free = !valid_q || bus.i_ready;
      ready     = (state_q == DATA) && slot_free;
      accept    = ready && bus.i_valid;
      step      = accept || ((state_q == TAIL) && slot_free);
      // Tail steps shift in zeros so the register drains back to state 0
      window    = {(state_q == DATA) ? bus.i_bit : 1'b0, sreg_q};
      code_d    = '0;
      for (int unsigned n = 0; n < CODE_NUM; n++)
         code_d[n] = ^(window & GEN_POLY[n*CONSTR_LEN +: CONSTR_LEN]);

      state_d   = state_q;
      sreg_d    = sreg_q;
      bcnt_d    = bcnt_q;
      tcnt_d    = tcnt_q;
      last_step = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.i_start) begin
               state_d = DATA;
               sreg_d  = '0;
               bcnt_d  = '0;
            end
         end
         DATA: begin
            if (accept) begin
               sreg_d = window[CONSTR_LEN-1:1];
               bcnt_d = bcnt_q + 1'b1;
               if (bcnt_q == BW'(FRAME_LEN - 1)) begin
                  state_d = TAIL;
                  tcnt_d  = '0;
               end
            end
         end
         TAIL: begin
            if (step) begin
               sreg_d = window[CONSTR_LEN-1:1];
               tcnt_d = tcnt_q + 1'b1;
               if (tcnt_q == TW'(CONSTR_LEN - 2)) begin
                  last_step = 1'b1;
                  state_d   = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sreg_q  <= '0;
         bcnt_q  <= '0;
         tcnt_q  <= '0;
         code_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         sreg_q <= sreg_d;
         bcnt_q <= bcnt_d;
         tcnt_q <= tcnt_d;
         // A step while the sink drains is a back-to-back transfer, no bubble
         if (step) begin
            code_q  <= code_d;
            valid_q <= 1'b1;
            last_q  <= last_step;
         end else if (bus.i_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
         end
      end
   end

   assign bus.o_ready = ready;
   assign bus.o_code  = code_q;
   assign bus.o_valid = valid_q;
   assign bus.o_last  = last_q;
   assign bus.o_busy  = (state_q != IDLE);
endmodule

// File: tb/tb_conv_encoder.sv
// Randomized bench for conv_encoder: a frame-level reference encoder fills an
// expected-codeword queue, and every sink transfer is compared against it.
module tb_conv_encoder;
   localparam int                 K   = 3;
   localparam int                 CN  = 2;
   localparam int                 FL  = 4;
   localparam logic [CN*K-1:0]    GEN = {3'b101, 3'b111};

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   conv_encoder_if #(.CODE_NUM(CN)) bus ();

   conv_encoder #(
      .CONSTR_LEN(K),
      .CODE_NUM  (CN),
      .GEN_POLY  (GEN),
      .FRAME_LEN (FL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int            n_vec = 0;
   int            n_err = 0;
   logic [CN:0]   exp_q[$];
   logic [CN-1:0] log_q[$];
   logic          log_last[$];
   bit            in_data   = 0;
   int            idx       = 0;
   int            tail_left = 0;
   bit            prev_stall = 0;
   logic [CN-1:0] prev_code;
   logic          prev_last;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_vec++;
      if (got !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
      end
   endtask

   // Reference: codeword j = sum over taps t of gen bit (K-1-t) times input x[j-t], zero padded
   function automatic void model_push(input logic [FL-1:0] d);
      for (int j = 0; j < FL + K - 1; j++) begin
         logic [CN:0] w;
         w = '0;
         for (int n = 0; n < CN; n++) begin
            logic p;
            p = 1'b0;
            for (int t = 0; t < K; t++) begin
               int   i;
               logic x;
               i = j - t;
               x = (i >= 0 && i < FL) ? d[i] : 1'b0;
               p = p ^ (GEN[n*K + K - 1 - t] & x);
            end
            w[n] = p;
         end
         w[CN] = (j == FL + K - 2);
         exp_q.push_back(w);
      end
   endfunction

   task automatic tick();
      logic [CN:0] e;
      @(negedge clk);
      if (!rst) begin
         check("busy", bus.o_busy, (in_data || tail_left > 0));
         check("ready", bus.o_ready, in_data && (!bus.o_valid || bus.i_ready));
         if (prev_stall) begin
            check("hold_valid", bus.o_valid, 1);
            check("hold_code", bus.o_code, prev_code);
            check("hold_last", bus.o_last, prev_last);
         end
         if (bus.o_valid && bus.i_ready) begin
            if (exp_q.size() == 0) check("spurious_word", 1, 0);
            else begin
               e = exp_q.pop_front();
               check("code", bus.o_code, e[CN-1:0]);
               check("last", bus.o_last, e[CN]);
            end
            log_q.push_back(bus.o_code);
            log_last.push_back(bus.o_last);
         end
         prev_stall = bus.o_valid && !bus.i_ready;
         prev_code  = bus.o_code;
         prev_last  = bus.o_last;
         if (!in_data && tail_left > 0 && (!bus.o_valid || bus.i_ready))
            tail_left--;
         if (in_data && bus.i_valid && (!bus.o_valid || bus.i_ready)) begin
            idx++;
            if (idx == FL) begin
               in_data   = 0;
               tail_left = K - 1;
            end
         end
      end else begin
         prev_stall = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      bus.i_start = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_bit   = 1'b0;
      bus.i_ready = 1'b0;
      tick();
      tick();
      rst        = 1'b0;
      in_data    = 0;
      tail_left  = 0;
      prev_stall = 0;
      exp_q.delete();
      check("rst_valid", bus.o_valid, 0);
      check("rst_code", bus.o_code, 0);
      check("rst_last", bus.o_last, 0);
      check("rst_ready", bus.o_ready, 0);
      check("rst_busy", bus.o_busy, 0);
   endtask

   // mode 0: always valid/ready; 1: random gaps; 2: sink stalls for three cycles
   task automatic run_frame(input logic [FL-1:0] d, input int mode, input bit noise);
      int cyc;
      bus.i_start = 1'b1;
      bus.i_valid = 1'b0;
      bus.i_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      bus.i_start = 1'b0;
      model_push(d);
      in_data = 1;
      idx     = 0;
      cyc     = 0;
      while ((in_data || tail_left > 0) && cyc < 500) begin
         bus.i_bit   = (idx < FL) ? d[idx] : 1'($urandom_range(0, 1));
         bus.i_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         case (mode)
            1:       bus.i_ready = ($urandom_range(0, 3) != 0);
            2:       bus.i_ready = !(cyc >= 2 && cyc <= 4);
            default: bus.i_ready = 1'b1;
         endcase
         bus.i_start = noise && ($urandom_range(0, 3) == 0);
         tick();
         cyc++;
      end
      bus.i_start = 1'b0;
      if (cyc >= 500) check("frame_timeout", 0, 1);
   endtask

   task automatic drain();
      int cyc;
      cyc         = 0;
      bus.i_ready = 1'b1;
      bus.i_valid = 1'b0;
      while (exp_q.size() > 0 && cyc < 100) begin
         tick();
         cyc++;
      end
      if (cyc >= 100) check("drain_timeout", 0, 1);
      check("drained_valid", bus.o_valid, 0);
   endtask

   task automatic check_known_frame();
      logic [1:0] tbl[6];
      tbl = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11};
      check("known_len", log_q.size(), 6);
      for (int i = 0; i < 6 && i < log_q.size(); i++) begin
         check("known_code", log_q[i], tbl[i]);
         check("known_last", log_last[i], (i == 5));
      end
   endtask

   initial begin
      logic [FL-1:0] d;
      do_reset();

      log_q.delete(); log_last.delete();
      run_frame(4'b1101, 0, 0);
      drain();
      check_known_frame();

      run_frame('0, 0, 0);
      drain();

      log_q.delete(); log_last.delete();
      run_frame(4'b1101, 2, 0);
      drain();
      check_known_frame();

      // Abort a frame on its third data cycle, then replay the known frame
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      model_push(4'b1111);
      in_data = 1;
      idx     = 0;
      bus.i_valid = 1'b1; bus.i_ready = 1'b1; bus.i_bit = 1'b1;
      tick();
      tick();
      do_reset();
      log_q.delete(); log_last.delete();
      run_frame(4'b1101, 0, 0);
      drain();
      check_known_frame();

      for (int f = 0; f < 40; f++) begin
         d = FL'($urandom);
         run_frame(d, 1, 1);
         if ($urandom_range(0, 2) == 0) drain();
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
